// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital clock controller.
//   mode_t  : user-visible operating mode (also the set_mode display select)
//   phase_t : command sequencing phase, one cycle each
//   ctrl_t  : one counter's en/load/clear control triple
package clock_ctrl_pkg;
    localparam int CNT_W       = 6;
    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int HR_MAX_DEF  = 23;

    localparam int F_SEC = 0;
    localparam int F_MIN = 1;
    localparam int F_HR  = 2;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_ISSUE  = 2'd1,
        PH_SETTLE = 2'd2
    } phase_t;

    typedef struct packed {
        logic en;
        logic load;
        logic clear;
    } ctrl_t;
endpackage

// File: rtl/clock_time_controller_if.sv
// Controller <-> counter bank connection.
//   *_q            : counter outputs read back by the controller
//   *_en/load/clear: per-counter single-cycle commands
//   ld_val         : parallel-load value shared by all counters
// master = controller side, slave = counter bank side.
interface clock_time_controller_if;
    import clock_ctrl_pkg::*;

    logic [CNT_W-1:0] sec_q;
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] hr_q;
    logic             sec_en, sec_load, sec_clear;
    logic             min_en, min_load, min_clear;
    logic             hr_en, hr_load, hr_clear;
    logic [CNT_W-1:0] ld_val;

    modport master (
        input  sec_q, min_q, hr_q,
        output sec_en, sec_load, sec_clear,
        output min_en, min_load, min_clear,
        output hr_en, hr_load, hr_clear,
        output ld_val
    );

    modport slave (
        output sec_q, min_q, hr_q,
        input  sec_en, sec_load, sec_clear,
        input  min_en, min_load, min_clear,
        input  hr_en, hr_load, hr_clear,
        input  ld_val
    );
endinterface

// File: rtl/field_step.sv
// Combinational step helper for one time field.
//   q        : current field value
//   max_val  : terminal count
//   at_max   : q >= max_val (values above max count as wrap)
//   next_val : q+1, or 0 when at/above max
module field_step
    import clock_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0] q,
    input  logic [CNT_W-1:0] max_val,
    output logic             at_max,
    output logic [CNT_W-1:0] next_val
);
    assign at_max   = (q >= max_val);
    assign next_val = at_max ? '0 : CNT_W'(q + CNT_W'(1));
endmodule

// File: rtl/clock_time_controller.sv
// Digital clock sequencer: cascades sec/min/hr counters on tick_1hz and
// provides a button-driven set mode for hours and minutes.
//   clk, reset      : clock, asynchronous active-low reset
//   tick_1hz        : one-cycle pulse per second
//   btn_mode/btn_inc: one-cycle debounced button pulses
//   set_mode        : 0=RUN, 1=SET_HR, 2=SET_MIN
//   cnt             : counter bank connection (master side)
// All commands are registered single-cycle pulses; after a command the
// phase FSM spends ISSUE and SETTLE cycles so q is fresh before the next
// event is accepted. Events outside IDLE are dropped.
module clock_time_controller
    import clock_ctrl_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int HR_MAX  = HR_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick_1hz,
    input  logic                     btn_mode,
    input  logic                     btn_inc,
    output logic [1:0]               set_mode,
    clock_time_controller_if.master  cnt
);
    logic [CNT_W-1:0] q_arr    [3];
    logic [CNT_W-1:0] next_arr [3];
    logic [2:0]       at_max;

    assign q_arr[F_SEC] = cnt.sec_q;
    assign q_arr[F_MIN] = cnt.min_q;
    assign q_arr[F_HR]  = cnt.hr_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_step
            localparam int FMAX = (gi == F_SEC) ? SEC_MAX :
                                  (gi == F_MIN) ? MIN_MAX : HR_MAX;
            field_step u_step (
                .q        (q_arr[gi]),
                .max_val  (CNT_W'(FMAX)),
                .at_max   (at_max[gi]),
                .next_val (next_arr[gi])
            );
        end
    endgenerate

    mode_t            mode_reg, mode_next;
    phase_t           phase_reg, phase_next;
    ctrl_t [2:0]      ctrl_reg, ctrl_next;
    logic [CNT_W-1:0] ld_val_reg, ld_val_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg   <= MODE_RUN;
            phase_reg  <= PH_IDLE;
            ctrl_reg   <= '0;
            ld_val_reg <= '0;
        end else begin
            mode_reg   <= mode_next;
            phase_reg  <= phase_next;
            ctrl_reg   <= ctrl_next;
            ld_val_reg <= ld_val_next;
        end
    end

    always_comb begin
        mode_next   = mode_reg;
        phase_next  = phase_reg;
        ctrl_next   = '0;
        ld_val_next = ld_val_reg;
        case (phase_reg)
            PH_ISSUE:  phase_next = PH_SETTLE;
            PH_SETTLE: phase_next = PH_IDLE;
            default: begin
                if (btn_mode) begin
                    case (mode_reg)
                        MODE_SET_HR: mode_next = MODE_SET_MIN;
                        MODE_SET_MIN: begin
                            // Leaving set mode restarts the seconds at 0.
                            mode_next              = MODE_RUN;
                            ctrl_next[F_SEC].clear = 1'b1;
                            phase_next             = PH_ISSUE;
                        end
                        default: begin
                            mode_next              = MODE_SET_HR;
                            ctrl_next[F_SEC].clear = 1'b1;
                            phase_next             = PH_ISSUE;
                        end
                    endcase
                end else if (btn_inc) begin
                    // btn_inc outranks tick even in RUN, where it is a no-op.
                    if (mode_reg == MODE_SET_HR) begin
                        ctrl_next[F_HR].load = 1'b1;
                        ld_val_next          = next_arr[F_HR];
                        phase_next           = PH_ISSUE;
                    end else if (mode_reg == MODE_SET_MIN) begin
                        ctrl_next[F_MIN].load = 1'b1;
                        ld_val_next           = next_arr[F_MIN];
                        phase_next            = PH_ISSUE;
                    end
                end else if (tick_1hz && mode_reg == MODE_RUN) begin
                    // Each field wraps with clear; a carry ripples only while
                    // every lower field is at (or beyond) its terminal count.
                    ctrl_next[F_SEC].clear = at_max[F_SEC];
                    ctrl_next[F_SEC].en    = !at_max[F_SEC];
                    if (at_max[F_SEC]) begin
                        ctrl_next[F_MIN].clear = at_max[F_MIN];
                        ctrl_next[F_MIN].en    = !at_max[F_MIN];
                        if (at_max[F_MIN]) begin
                            ctrl_next[F_HR].clear = at_max[F_HR];
                            ctrl_next[F_HR].en    = !at_max[F_HR];
                        end
                    end
                    phase_next = PH_ISSUE;
                end
            end
        endcase
    end

    assign set_mode      = mode_reg;
    assign cnt.ld_val    = ld_val_reg;
    assign cnt.sec_en    = ctrl_reg[F_SEC].en;
    assign cnt.sec_load  = ctrl_reg[F_SEC].load;
    assign cnt.sec_clear = ctrl_reg[F_SEC].clear;
    assign cnt.min_en    = ctrl_reg[F_MIN].en;
    assign cnt.min_load  = ctrl_reg[F_MIN].load;
    assign cnt.min_clear = ctrl_reg[F_MIN].clear;
    assign cnt.hr_en     = ctrl_reg[F_HR].en;
    assign cnt.hr_load   = ctrl_reg[F_HR].load;
    assign cnt.hr_clear  = ctrl_reg[F_HR].clear;
endmodule

// File: tb/tb_clock_time_controller.sv
// Scoreboard bench for clock_time_controller: stimulus pushes the expected
// command pulse, a negedge monitor pops and compares every pulse it sees.
module tb_clock_time_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [1:0] set_mode;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    clock_time_controller_if cnt ();

    clock_time_controller dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .set_mode (set_mode),
        .cnt      (cnt.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {sec_en,sec_load,sec_clear,min_en,min_load,min_clear,hr_en,hr_load,hr_clear}
    localparam logic [8:0] SEC_EN  = 9'b100_000_000;
    localparam logic [8:0] SEC_CLR = 9'b001_000_000;
    localparam logic [8:0] MIN_EN  = 9'b000_100_000;
    localparam logic [8:0] MIN_LD  = 9'b000_010_000;
    localparam logic [8:0] MIN_CLR = 9'b000_001_000;
    localparam logic [8:0] HR_LD   = 9'b000_000_010;
    localparam logic [8:0] HR_CLR  = 9'b000_000_001;

    typedef struct {
        logic [8:0] ctrl;
        logic [5:0] ld;
        logic [1:0] mode;
        int         at_cyc;
        string      name;
    } exp_t;
    exp_t sb[$];

    logic [8:0] ctrl_now;
    assign ctrl_now = {cnt.sec_en, cnt.sec_load, cnt.sec_clear,
                       cnt.min_en, cnt.min_load, cnt.min_clear,
                       cnt.hr_en, cnt.hr_load, cnt.hr_clear};

    // Monitor: every cycle with any control high must match the queue head.
    always @(negedge clk) begin
        if (reset && ctrl_now != 9'b0) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cmd: got ctrl=%b ld=%0d mode=%0d cyc=%0d, required no command",
                         ctrl_now, cnt.ld_val, set_mode, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks += 4;
                if (ctrl_now !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s.ctrl: got %b, required %b", e.name, ctrl_now, e.ctrl);
                end
                if (cnt.ld_val !== e.ld) begin
                    errors++;
                    $display("FAIL %s.ld_val: got %0d, required %0d", e.name, cnt.ld_val, e.ld);
                end
                if (set_mode !== e.mode) begin
                    errors++;
                    $display("FAIL %s.set_mode: got %0d, required %0d", e.name, set_mode, e.mode);
                end
                if (cyc != e.at_cyc) begin
                    errors++;
                    $display("FAIL %s.latency: got cycle %0d, required cycle %0d", e.name, cyc, e.at_cyc);
                end
                $display("txn %s ctrl=%b ld=%0d mode=%0d cyc=%0d", e.name, ctrl_now, cnt.ld_val, set_mode, cyc);
            end
        end
    end

    task automatic set_q(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h);
        cnt.sec_q = s; cnt.min_q = m; cnt.hr_q = h;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s.timeout: got %0d pending, required 0 pending", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // One-cycle event pulse; push_exp selects whether a command is expected.
    task automatic event_pulse(input logic t, input logic m, input logic i,
                               input logic push_exp, input logic [8:0] ctrl,
                               input logic [5:0] ld, input logic [1:0] mode,
                               input string name);
        @(negedge clk);
        tick_1hz = t; btn_mode = m; btn_inc = i;
        if (push_exp) sb.push_back('{ctrl: ctrl, ld: ld, mode: mode, at_cyc: cyc + 1, name: name});
        @(negedge clk);
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        wait_drain(name);
    endtask

    task automatic check_mode(input logic [1:0] exp, input string name);
        checks++;
        if (set_mode !== exp) begin
            errors++;
            $display("FAIL %s: got set_mode=%0d, required %0d", name, set_mode, exp);
        end else
            $display("txn %s set_mode=%0d", name, set_mode);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (ctrl_now !== 9'b0 || cnt.ld_val !== 6'd0 || set_mode !== 2'd0) begin
            errors++;
            $display("FAIL %s: got ctrl=%b ld=%0d mode=%0d, required all 0",
                     name, ctrl_now, cnt.ld_val, set_mode);
        end else
            $display("txn %s all outputs 0", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_q(6'd0, 6'd0, 6'd0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        event_pulse(1, 0, 0, 1, SEC_EN, 6'd0, 2'd0, "tick_000");
        set_q(6'd59, 6'd59, 6'd23);
        event_pulse(1, 0, 0, 1, SEC_CLR | MIN_CLR | HR_CLR, 6'd0, 2'd0, "tick_full_wrap");
        set_q(6'd59, 6'd12, 6'd5);
        event_pulse(1, 0, 0, 1, SEC_CLR | MIN_EN, 6'd0, 2'd0, "tick_min_carry");
        set_q(6'd62, 6'd3, 6'd1);
        event_pulse(1, 0, 0, 1, SEC_CLR | MIN_EN, 6'd0, 2'd0, "tick_garbage_sec");

        // Three back-to-back ticks: only the first is accepted.
        set_q(6'd0, 6'd0, 6'd0);
        @(negedge clk);
        tick_1hz = 1'b1;
        sb.push_back('{ctrl: SEC_EN, ld: 6'd0, mode: 2'd0, at_cyc: cyc + 1, name: "tick_burst"});
        repeat (3) @(negedge clk);
        tick_1hz = 1'b0;
        wait_drain("tick_burst");

        // Set sequence.
        event_pulse(0, 1, 0, 1, SEC_CLR, 6'd0, 2'd1, "mode_to_set_hr");
        check_mode(2'd1, "mode_is_set_hr");
        set_q(6'd0, 6'd0, 6'd5);
        event_pulse(0, 0, 1, 1, HR_LD, 6'd6, 2'd1, "inc_hr_5");
        set_q(6'd0, 6'd0, 6'd23);
        event_pulse(0, 0, 1, 1, HR_LD, 6'd0, 2'd1, "inc_hr_23");
        event_pulse(1, 0, 0, 0, 9'b0, 6'd0, 2'd1, "tick_frozen_hr");
        event_pulse(0, 1, 1, 0, 9'b0, 6'd0, 2'd2, "mode_inc_same_cycle");
        check_mode(2'd2, "mode_is_set_min");
        set_q(6'd0, 6'd59, 6'd0);
        event_pulse(0, 0, 1, 1, MIN_LD, 6'd0, 2'd2, "inc_min_59");
        set_q(6'd0, 6'd7, 6'd0);
        event_pulse(0, 0, 1, 1, MIN_LD, 6'd8, 2'd2, "inc_min_7");
        event_pulse(1, 0, 0, 0, 9'b0, 6'd8, 2'd2, "tick_frozen_min");
        event_pulse(0, 1, 0, 1, SEC_CLR, 6'd8, 2'd0, "mode_to_run");
        check_mode(2'd0, "mode_is_run");

        // Reset asserted while a command is in ISSUE.
        @(negedge clk);
        btn_mode = 1'b1;
        @(posedge clk);
        #1 btn_mode = 1'b0;
        checks++;
        if (ctrl_now !== SEC_CLR || set_mode !== 2'd1) begin
            errors++;
            $display("FAIL issue_before_reset: got ctrl=%b mode=%0d, required %b mode=1",
                     ctrl_now, set_mode, SEC_CLR);
        end else
            $display("txn issue_before_reset ctrl=%b mode=%0d", ctrl_now, set_mode);
        reset = 1'b0;
        #1 check_all_zero("async_reset_mid_issue");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        set_q(6'd10, 6'd0, 6'd0);
        event_pulse(1, 0, 0, 1, SEC_EN, 6'd0, 2'd0, "tick_after_reset");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
